// File: rtl/mem_bus_initiator.sv
// Word-memory bus initiator: converts one-cycle CPU access commands into a
// req/gnt/rvalid transaction with done/error status and a bounded wait.
module mem_bus_initiator #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_start,
  input  logic             cpu_write,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_busy,
  output logic             cpu_done,
  output logic             cpu_error,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             limit_c;

  // Last cycle of the REQ+WAIT budget; a same-cycle exit event still wins.
  assign limit_c = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_start) begin
          we_d    = cpu_write;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cnt_d   = '0;
          state_d = (cpu_addr[1:0] != 2'b00) ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (limit_c) begin
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = S_DONE;
        end else if (limit_c) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      bus_req   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cpu_busy  <= (state_d != S_IDLE);
      cpu_done  <= (state_d == S_DONE);
      cpu_error <= (state_d == S_ERR);
      bus_req   <= (state_d == S_REQ);
    end
  end

  assign cpu_rdata = rdata_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator; expected completions are queued at
// issue time and checked by an independent monitor on each done/error pulse.
module tb_mem_bus_initiator;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cpu_start, cpu_write;
  logic [WIDTH-1:0] cpu_addr, cpu_wdata;
  logic             cpu_busy, cpu_done, cpu_error;
  logic [WIDTH-1:0] cpu_rdata;
  logic             bus_req, bus_we;
  logic [WIDTH-1:0] bus_addr, bus_wdata;
  logic             bus_gnt, bus_rvalid;
  logic [WIDTH-1:0] bus_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lo;
    int          hi;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   s;

  mem_bus_initiator #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_start  (cpu_start),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_error  (cpu_error),
    .cpu_rdata  (cpu_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [31:0] rd, input int lo, input int hi);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    e.lo    = lo;
    e.hi    = hi;
    sb_q.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cpu_done || cpu_error) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse cycle=%0d done=%b error=%b", cyc, cpu_done, cpu_error);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_done", 32'(cpu_done), 32'(!e.err));
        chk("sb_error", 32'(cpu_error), 32'(e.err));
        chk("sb_rdata", cpu_rdata, e.rdata);
        total++;
        if (cyc < e.lo || cyc > e.hi) begin
          bad++;
          $display("FAIL sb_latency got cycle=%0d expected %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    cpu_start  = 1'b0;
    cpu_write  = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(cpu_busy), 0);
    chk("rst_done", 32'(cpu_done), 0);
    chk("rst_error", 32'(cpu_error), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    reset_n = 1'b1;
    tick();

    // Read, grant on first REQ cycle, rvalid one cycle later.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0010;
    s = cyc; push(1'b0, 32'hDEAD_BEEF, s + 3, s + 3);
    tick(); cpu_start = 1'b0; bus_gnt = 1'b1;
    #2;
    chk("rd_req", 32'(bus_req), 1);
    chk("rd_addr", bus_addr, 32'h0000_0010);
    chk("rd_we", 32'(bus_we), 0);
    chk("rd_busy", 32'(cpu_busy), 1);
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #2;
    chk("rd_wait_req", 32'(bus_req), 0);
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    tick();

    // Write with the grant held off for three REQ cycles.
    cpu_start = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h1234_5678;
    s = cyc; push(1'b0, 32'hDEAD_BEEF, s + 5, s + 5);
    for (int i = 1; i <= 4; i++) begin
      tick(); cpu_start = 1'b0; cpu_wdata = '0; bus_gnt = (i == 4);
      #2;
      chk("wr_req", 32'(bus_req), 1);
      chk("wr_addr", bus_addr, 32'h0000_0020);
      chk("wr_wdata", bus_wdata, 32'h1234_5678);
      chk("wr_we", 32'(bus_we), 1);
    end
    tick(); bus_gnt = 1'b0;
    #2;
    chk("wr_req_drop", 32'(bus_req), 0);
    tick();

    // Misaligned address: error, no bus request.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0013;
    s = cyc; push(1'b1, 32'hDEAD_BEEF, s + 1, s + 2);
    for (int i = 0; i < 3; i++) begin
      tick(); cpu_start = 1'b0;
      #2;
      chk("mis_no_req", 32'(bus_req), 0);
    end
    tick();

    // Read granted but never answered: timeout, then a stray late rvalid.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0030;
    s = cyc; push(1'b1, 32'hDEAD_BEEF, s + 17, s + 17);
    tick(); cpu_start = 1'b0; bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0;
    repeat (16) tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    chk("to_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    chk("to_idle", 32'(cpu_busy), 0);
    tick();

    // cpu_start held high: exactly one access, next accepted after DONE.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0040;
    s = cyc; push(1'b0, 32'hCAFE_F00D, s + 3, s + 3);
    tick(); bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick(); bus_rvalid = 1'b0;
    #2;
    chk("hold_busy_done", 32'(cpu_busy), 1);
    tick();
    #2;
    chk("hold_idle", 32'(cpu_busy), 0);
    push(1'b0, 32'h0123_4567, s + 7, s + 7);
    tick(); cpu_start = 1'b0; bus_gnt = 1'b1;
    #2;
    chk("hold_req2", 32'(bus_req), 1);
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0123_4567;
    tick(); bus_rvalid = 1'b0;
    tick();

    // Asynchronous reset while waiting for read data.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0050;
    tick(); cpu_start = 1'b0; bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 0);
    chk("arst_busy", 32'(cpu_busy), 0);
    chk("arst_rdata", cpu_rdata, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Normal read after reset.
    cpu_start = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0060;
    s = cyc; push(1'b0, 32'h600D_CAFE, s + 3, s + 3);
    tick(); cpu_start = 1'b0; bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h600D_CAFE;
    tick(); bus_rvalid = 1'b0;
    repeat (3) tick();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
